if_resp_buffer: RTL and testbench

- IF-stage receiving end of the instruction-fetch path: the pre-IF stage issues fetch requests (PC and address handshake), and this block pairs each returned instruction with its PC, in order.
- It buffers the {pc, inst} pairs and presents them to ID under a valid/ready handshake.
- On exception flush it drops all buffered entries and discards the in-flight responses of cancelled requests.

---
 rtl/if_resp_buffer_pkg.sv | 18 +
 rtl/if_cancel_cnt.sv | 52 +++++
 rtl/if_resp_buffer.sv | 157 +++++++++++++++
 tb/tb_if_resp_buffer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_resp_buffer_pkg.sv
// Shared widths for the IF fetch-response buffer and the IF-to-ID {pc, inst} bus.
package if_resp_buffer_pkg;

    localparam int IF_BUF_DEPTH = 2;
    localparam int PC_BUS_WD    = 32;
    localparam int INST_BUS_WD  = 32;

    function automatic int pair_bus_wd(input int pc_w, input int inst_w);
        return pc_w + inst_w;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int IF_TO_ID_BUS_WD = pair_bus_wd(PC_BUS_WD, INST_BUS_WD);

endpackage

// File: rtl/if_cancel_cnt.sv
// Counts responses still owed to requests cancelled by a flush and flags each one for dropping.
module if_cancel_cnt
    import if_resp_buffer_pkg::*;
#(
    parameter int DEPTH = IF_BUF_DEPTH,
    parameter int CNT_W = cnt_width(IF_BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             req_fire_i,
    input  logic             resp_valid_i,
    input  logic [CNT_W-1:0] undone_i,
    output logic             resp_drop_o,
    output logic [CNT_W-1:0] cancel_cnt_o
);

    localparam int SUM_W = CNT_W + 2;

    logic [CNT_W-1:0] cancel_cnt_q;
    logic [CNT_W-1:0] cancel_cnt_d;
    logic [SUM_W-1:0] flush_sum;
    logic [SUM_W-1:0] flush_net;

    // On flush every undone entry plus a same-cycle request becomes owed; a same-cycle response pays one back.
    always_comb begin
        flush_sum = {2'b00, cancel_cnt_q} + {2'b00, undone_i} + SUM_W'(req_fire_i);
        flush_net = flush_sum;
        if (resp_valid_i && (flush_sum != '0)) begin
            flush_net = flush_sum - SUM_W'(1);
        end

        cancel_cnt_d = cancel_cnt_q;
        if (flush_i) begin
            cancel_cnt_d = (flush_net > SUM_W'(DEPTH)) ? CNT_W'(DEPTH) : flush_net[CNT_W-1:0];
        end else if (resp_valid_i && (cancel_cnt_q != '0)) begin
            cancel_cnt_d = cancel_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cancel_cnt_q <= '0;
        end else begin
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

    assign resp_drop_o  = resp_valid_i && (flush_i || (cancel_cnt_q != '0));
    assign cancel_cnt_o = cancel_cnt_q;

endmodule

// File: rtl/if_resp_buffer.sv
// In-order {pc, inst} pairing buffer between fetch issue and ID.
// Define IF_RESP_BYPASS_EN to forward a response to ID in the same cycle it returns.
module if_resp_buffer
    import if_resp_buffer_pkg::*;
#(
    parameter int DEPTH  = IF_BUF_DEPTH,
    parameter int PC_W   = PC_BUS_WD,
    parameter int INST_W = INST_BUS_WD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              excep_flush_i,
    input  logic              req_fire_i,
    input  logic [PC_W-1:0]   req_pc_i,
    input  logic              resp_valid_i,
    input  logic [INST_W-1:0] resp_inst_i,
    output logic              can_issue_o,
    output logic              out_valid_o,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [INST_W-1:0] out_inst_o,
    input  logic              out_ready_i
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);
    localparam int PAIR_W = pair_bus_wd(PC_W, INST_W);

    logic [PC_W-1:0]   pc_q     [DEPTH];
    logic [PC_W-1:0]   pc_d     [DEPTH];
    logic [INST_W-1:0] inst_q   [DEPTH];
    logic [INST_W-1:0] inst_d   [DEPTH];
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  done_d;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  head_d;
    logic [PTR_W-1:0]  tail_q;
    logic [PTR_W-1:0]  tail_d;
    logic [PTR_W-1:0]  resp_ptr_q;
    logic [PTR_W-1:0]  resp_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic [CNT_W-1:0]  cancel_cnt;
    logic              resp_drop;
    logic [CNT_W-1:0]  done_cnt;
    logic [CNT_W-1:0]  undone;
    logic              fire;
    logic              resp_take;
    logic              head_done;
    logic              bypass_hit;
    logic              pop;
    logic              bypass_pop;
    logic [INST_W-1:0] head_inst;
    logic [PAIR_W-1:0] head_pair;

    if_cancel_cnt #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_cancel_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (excep_flush_i),
        .req_fire_i   (fire),
        .resp_valid_i (resp_valid_i),
        .undone_i     (undone),
        .resp_drop_o  (resp_drop),
        .cancel_cnt_o (cancel_cnt)
    );

    // Done bits are cleared on pop, so only live entries contribute to done_cnt.
    always_comb begin
        done_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            done_cnt = done_cnt + CNT_W'(done_q[i]);
        end
    end

    assign undone      = count_q - done_cnt;
    assign can_issue_o = ({1'b0, count_q} + {1'b0, cancel_cnt}) < (CNT_W + 1)'(DEPTH);
    assign fire        = req_fire_i && can_issue_o;
    assign resp_take   = resp_valid_i && !resp_drop && (undone != '0);
    assign head_done   = done_q[head_q] && (count_q != '0);

`ifdef IF_RESP_BYPASS_EN
    assign bypass_hit = !done_q[head_q] && (count_q != '0) && (resp_ptr_q == head_q)
                        && resp_valid_i && (cancel_cnt == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign out_valid_o = (head_done || bypass_hit) && !excep_flush_i;
    assign pop         = out_valid_o && out_ready_i;
    assign bypass_pop  = bypass_hit && pop;
    assign head_inst   = bypass_hit ? resp_inst_i : inst_q[head_q];
    assign head_pair   = out_valid_o ? {pc_q[head_q], head_inst} : '0;
    assign out_pc_o    = head_pair[PAIR_W-1 -: PC_W];
    assign out_inst_o  = head_pair[INST_W-1:0];

    // A bypassed pop consumes the response directly, so its slot is never marked done.
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        done_d     = done_q;
        head_d     = head_q;
        tail_d     = tail_q;
        resp_ptr_d = resp_ptr_q;
        count_d    = count_q;
        if (excep_flush_i) begin
            done_d     = '0;
            head_d     = '0;
            tail_d     = '0;
            resp_ptr_d = '0;
            count_d    = '0;
        end else begin
            if (fire) begin
                pc_d[tail_q]   = req_pc_i;
                done_d[tail_q] = 1'b0;
                tail_d         = tail_q + PTR_W'(1);
            end
            if (resp_take) begin
                if (!bypass_pop) begin
                    inst_d[resp_ptr_q] = resp_inst_i;
                    done_d[resp_ptr_q] = 1'b1;
                end
                resp_ptr_d = resp_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                done_d[head_q] = 1'b0;
                head_d         = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(fire) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            resp_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            resp_ptr_q <= resp_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset; it is only visible while its done bit or the bypass qualifies it.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

endmodule

// File: tb/tb_if_resp_buffer.sv
// Scoreboard bench for if_resp_buffer; IF_RESP_BYPASS_EN selects the zero-latency expectations.
module tb_if_resp_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        excep_flush_i;
    logic        req_fire_i;
    logic [31:0] req_pc_i;
    logic        resp_valid_i;
    logic [31:0] resp_inst_i;
    logic        can_issue_o;
    logic        out_valid_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_inst_o;
    logic        out_ready_i;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_pair;

`ifdef IF_RESP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    if_resp_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .excep_flush_i (excep_flush_i),
        .req_fire_i    (req_fire_i),
        .req_pc_i      (req_pc_i),
        .resp_valid_i  (resp_valid_i),
        .resp_inst_i   (resp_inst_i),
        .can_issue_o   (can_issue_o),
        .out_valid_o   (out_valid_o),
        .out_pc_o      (out_pc_o),
        .out_inst_o    (out_inst_o),
        .out_ready_i   (out_ready_i)
    );

    // Every transfer to ID must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL pop_unexpected: got pc=%h inst=%h, required no transfer", out_pc_o, out_inst_o);
            end else begin
                exp_pair = exp_q.pop_front();
                if ({out_pc_o, out_inst_o} !== exp_pair) begin
                    errors++;
                    $display("[TB] FAIL pop_pair: got pc=%h inst=%h, required pc=%h inst=%h",
                             out_pc_o, out_inst_o, exp_pair[63:32], exp_pair[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic set_in(input logic fire, input logic [31:0] pc, input logic rv,
                          input logic [31:0] inst, input logic rdy, input logic fl);
        req_fire_i    = fire;
        req_pc_i      = pc;
        resp_valid_i  = rv;
        resp_inst_i   = inst;
        out_ready_i   = rdy;
        excep_flush_i = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: %0d pairs still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({out_valid_o, out_pc_o, out_inst_o} !== 65'h0) begin
            errors++;
            $display("[TB] FAIL reset_out: got v=%b pc=%h inst=%h, required all 0", out_valid_o, out_pc_o, out_inst_o);
        end
        checks++;
        if (can_issue_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_can_issue: got %b, required 1", can_issue_o);
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_in_order();
        set_in(1'b1, 32'h1c000000, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (can_issue_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL order_idle: got can_issue=%b v=%b, required 1 0", can_issue_o, out_valid_o);
        end
        next_cycle();
        set_in(1'b1, 32'h1c000004, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (can_issue_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL order_full: got can_issue=%b, required 0", can_issue_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h02800000, 1'b1, 1'b0);
        exp_q.push_back({32'h1c000000, 32'h02800000});
        @(negedge clk);
        checks++;
        if (out_valid_o !== BYP) begin
            errors++;
            $display("[TB] FAIL order_lat0: got v=%b in response cycle, required %b", out_valid_o, BYP);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid_o !== !BYP) begin
            errors++;
            $display("[TB] FAIL order_lat1: got v=%b after response, required %b", out_valid_o, !BYP);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h02800400, 1'b1, 1'b0);
        exp_q.push_back({32'h1c000004, 32'h02800400});
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        @(negedge clk);
        checks++;
        if (can_issue_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL order_end: got can_issue=%b v=%b, required 1 0", can_issue_o, out_valid_o);
        end
        next_cycle();
        check_drained("order");
    endtask

    task automatic test_full_wrap();
        set_in(1'b1, 32'h1c000010, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 32'h1c000014, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 32'h1c0000ff, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (can_issue_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_full: got can_issue=%b, required 0", can_issue_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h02801010, 1'b0, 1'b0);
        exp_q.push_back({32'h1c000010, 32'h02801010});
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h02801414, 1'b0, 1'b0);
        exp_q.push_back({32'h1c000014, 32'h02801414});
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || out_pc_o !== 32'h1c000010) begin
            errors++;
            $display("[TB] FAIL wrap_hold: got v=%b pc=%h, required 1 1c000010", out_valid_o, out_pc_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_inst_o !== 32'h02801010) begin
            errors++;
            $display("[TB] FAIL wrap_inst: got %h, required 02801010", out_inst_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        set_in(1'b1, 32'h1c000018, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h02801818, 1'b1, 1'b0);
        exp_q.push_back({32'h1c000018, 32'h02801818});
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        check_drained("wrap");
    endtask

    task automatic test_flush_cancel();
        set_in(1'b1, 32'h1c000100, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b1, 32'h1c000104, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cancel_flush_v: got v=%b, required 0", out_valid_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (can_issue_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cancel_two_owed: got can_issue=%b, required 0", can_issue_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'hdead0001, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b1, 32'h1c008000, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (can_issue_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cancel_one_owed: got can_issue=%b, required 1", can_issue_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'hdead0002, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cancel_drop_v: got v=%b on dropped response, required 0", out_valid_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h02800c00, 1'b1, 1'b0);
        exp_q.push_back({32'h1c008000, 32'h02800c00});
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        check_drained("cancel");
    endtask

    task automatic test_flush_mixed();
        set_in(1'b1, 32'h1c000200, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b1, 32'h1c000204, 1'b1, 32'hdead0003, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || out_inst_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mixed_flush_v: got v=%b inst=%h, required 0 0", out_valid_o, out_inst_o);
        end
        next_cycle();
        set_in(1'b1, 32'h1c000208, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (can_issue_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mixed_owed: got can_issue=%b, required 1", can_issue_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'hdead0004, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h02802000, 1'b1, 1'b0);
        exp_q.push_back({32'h1c000208, 32'h02802000});
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        check_drained("mixed");
    endtask

    task automatic test_flush_done_head();
        set_in(1'b1, 32'h1c000400, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h02801000, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || out_pc_o !== 32'h1c000400) begin
            errors++;
            $display("[TB] FAIL donehead_ready: got v=%b pc=%h, required 1 1c000400", out_valid_o, out_pc_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || out_pc_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL donehead_flush: got v=%b pc=%h, required 0 0", out_valid_o, out_pc_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || can_issue_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL donehead_after: got v=%b can_issue=%b, required 0 1", out_valid_o, can_issue_o);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 32'h1c000500, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        next_cycle();
        set_in(1'b1, 32'h1c000504, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (can_issue_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_pre: got can_issue=%b, required 0", can_issue_o);
        end
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({out_valid_o, out_pc_o, out_inst_o} !== 65'h0 || can_issue_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_out: got v=%b pc=%h inst=%h can_issue=%b, required 0 0 0 1",
                     out_valid_o, out_pc_o, out_inst_o, can_issue_o);
        end
        next_cycle();
        rst_n = 1'b1;
        set_in(1'b1, 32'h1c000600, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h02803000, 1'b1, 1'b0);
        exp_q.push_back({32'h1c000600, 32'h02803000});
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        check_drained("rstmid");
    endtask

`ifdef IF_RESP_BYPASS_EN
    task automatic test_bypass();
        set_in(1'b1, 32'h1c000300, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h03400000, 1'b1, 1'b0);
        exp_q.push_back({32'h1c000300, 32'h03400000});
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || out_inst_o !== 32'h03400000) begin
            errors++;
            $display("[TB] FAIL bypass_same: got v=%b inst=%h, required 1 03400000", out_valid_o, out_inst_o);
        end
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || can_issue_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bypass_after: got v=%b can_issue=%b, required 0 1", out_valid_o, can_issue_o);
        end
        next_cycle();
        check_drained("bypass");
    endtask
`endif

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_flush_cancel();
        test_flush_mixed();
        test_flush_done_head();
        test_reset_mid();
`ifdef IF_RESP_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
